// File: rtl/gaussian_frame_writer.sv
// Frame-buffer writer at the sink of the GAUSSIAN stream: drops pipeline-fill strobes, tracks x/y, queues pixels.
// Build option: define DOWNSAMPLE_EN for 2:1 decimation (even x, even y only) feeding the next octave.
module gaussian_frame_writer #(
   parameter int WIDTH      = 400,
   parameter int HEIGHT     = 300,
   parameter int LAT        = 2*WIDTH+2,
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 17
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              Clk_en,
   input  logic [7:0]        din,
   input  logic              frame_start,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int SKIP_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int X_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int Y_W    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((LAT > 0) ? LAT - 1 : 0);
   localparam logic [X_W-1:0]    X_LAST    = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(HEIGHT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FILL, CAPTURE, DRAIN} state_t;

   state_t              state;
   logic [SKIP_W-1:0]   skip_cnt;
   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [ADDR_W-1:0]   addr_cnt;

   logic [7:0]          mem_data [FIFO_DEPTH];
   logic [ADDR_W-1:0]   mem_addr [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;

   logic                full;
   logic                pop;
   logic                cap;
   logic                keep;
   logic                push;

   assign wr_valid = (count != '0);
   assign wr_addr  = mem_addr[rd_ptr];
   assign wr_data  = mem_data[rd_ptr];

   assign full = (count == CNT_FULL);
   assign pop  = wr_valid & wr_ready;
   // A strobe coinciding with frame_start belongs to the new frame, never to CAPTURE.
   assign cap  = (state == CAPTURE) & Clk_en & ~frame_start;

`ifdef DOWNSAMPLE_EN
   assign keep = ~x[0] & ~y[0];
`else
   assign keep = 1'b1;
`endif

   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push = cap & keep & (~full | pop);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_addr[i] <= '0;
         end
      end else if (frame_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= din;
            mem_addr[wr_ptr] <= addr_cnt;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         skip_cnt   <= '0;
         x          <= '0;
         y          <= '0;
         addr_cnt   <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start) begin
            x        <= '0;
            y        <= '0;
            addr_cnt <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
            if (LAT == 0 || (LAT == 1 && Clk_en)) begin
               state    <= CAPTURE;
               skip_cnt <= '0;
            end else begin
               state    <= FILL;
               skip_cnt <= Clk_en ? SKIP_W'(1) : '0;
            end
         end else begin
            case (state)
               IDLE: ;
               FILL: begin
                  if (Clk_en) begin
                     if (skip_cnt == SKIP_LAST) begin
                        state    <= CAPTURE;
                        skip_cnt <= '0;
                     end else begin
                        skip_cnt <= skip_cnt + 1'b1;
                     end
                  end
               end
               CAPTURE: begin
                  if (Clk_en) begin
                     // Address advances even for dropped pixels so later writes land correctly.
                     if (keep) begin
                        addr_cnt <= addr_cnt + 1'b1;
                        if (full && !pop)
                           overflow <= 1'b1;
                     end
                     if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                           y     <= '0;
                           state <= DRAIN;
                        end else begin
                           y <= y + 1'b1;
                        end
                     end else begin
                        x <= x + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  // Finish on the same edge that accepts the final write.
                  if (count == '0 || (count == CNT_W'(1) && pop)) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gaussian_frame_writer.sv
// Directed bench for gaussian_frame_writer; expected writes are queued as pixels are strobed in.
module tb_gaussian_frame_writer;
   localparam int W  = 8;
   localparam int H  = 4;
   localparam int L  = 18;
   localparam int D  = 4;
   localparam int AW = 17;
`ifdef DOWNSAMPLE_EN
   localparam int NPIX = (W/2)*(H/2);
`else
   localparam int NPIX = W*H;
`endif

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          Clk_en = 1'b0;
   logic [7:0]    din = '0;
   logic          frame_start = 1'b0;
   logic          wr_ready = 1'b0;
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   logic          frame_done;
   logic          overflow;

   always #5 Clk = ~Clk;

   gaussian_frame_writer #(.WIDTH(W), .HEIGHT(H), .LAT(L), .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Clk_en(Clk_en), .din(din), .frame_start(frame_start),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_done(frame_done), .overflow(overflow));

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t           exp_q[$];
   int            checks = 0;
   int            failures = 0;
   int            wr_cnt = 0;
   int            done_cnt = 0;
   int            sidx = 0;
   bit            active = 1'b0;
   int            drop_lo = -1;
   int            drop_hi = -1;
   logic          stall_prev = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [7:0]    prev_data = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer: every accepted write must match the queue head.
   always @(negedge Clk) begin
      if (Reset_n) begin
         if (stall_prev && wr_valid) begin
            chk("stall_addr", 32'(wr_addr), 32'(prev_addr));
            chk("stall_data", 32'(wr_data), 32'(prev_data));
         end
         if (wr_valid && wr_ready) begin
            wr_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
               failures++;
               $error("FAIL unexpected_write got addr=%0h expected no write", wr_addr);
            end
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(wr_addr), 32'(e.addr));
               chk("wr_data", 32'(wr_data), 32'(e.data));
            end
         end
         if (frame_done) begin
            done_cnt++;
            chk("busy_at_done", 32'(busy), 32'(0));
         end
         stall_prev = wr_valid && !wr_ready;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic expect_pixel(input int p, input logic [7:0] d);
      int  xx, yy, a;
      bit  k;
      wr_t e;
      xx = p % W;
      yy = p / W;
`ifdef DOWNSAMPLE_EN
      k = (xx % 2 == 0) && (yy % 2 == 0);
      a = (yy/2)*(W/2) + xx/2;
`else
      k = 1'b1;
      a = p;
`endif
      if (k && !(a >= drop_lo && a <= drop_hi)) begin
         e.addr = AW'(a);
         e.data = d;
         exp_q.push_back(e);
      end
   endtask

   task automatic drive(input logic en, input logic [7:0] d, input logic fs, input logic rdy);
      int p;
      Clk_en = en; din = d; frame_start = fs; wr_ready = rdy;
      if (fs) begin
         active = 1'b1;
         sidx = en ? 1 : 0;
      end else if (active && en) begin
         p = sidx - L;
         if (p >= 0 && p < W*H) expect_pixel(p, d);
         if (p == W*H-1) active = 1'b0;
         sidx++;
      end
      @(posedge Clk); #1;
      Clk_en = 1'b0; frame_start = 1'b0;
      if (fs) exp_q.delete();
   endtask

   task automatic wait_done(input string tag, input int d0, input int exp_writes, input bit toggle);
      int n;
      n = 0;
      while (done_cnt == d0 && n < 300) begin
         drive(1'b0, 8'd0, 1'b0, toggle ? logic'(n % 2 == 0) : 1'b1);
         n++;
      end
      for (int i = 0; i < 3; i++) drive(1'b0, 8'd0, 1'b0, 1'b1);
      chk({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(1));
      chk({tag, "_writes"}, 32'(wr_cnt), 32'(exp_writes));
      chk({tag, "_queue_left"}, 32'(exp_q.size()), 32'(0));
      chk({tag, "_busy_idle"}, 32'(busy), 32'(0));
      chk({tag, "_valid_idle"}, 32'(wr_valid), 32'(0));
   endtask

   initial begin
      int d0;
      int cyc;

      // Reset values, then a mid-CAPTURE asynchronous reset with 3 queued entries.
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_valid", 32'(wr_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(frame_done), 32'(0));
      chk("rst_ovf", 32'(overflow), 32'(0));
      chk("rst_addr", 32'(wr_addr), 32'(0));
      chk("rst_data", 32'(wr_data), 32'(0));
      Reset_n = 1'b1;
      drive(1'b0, 8'd0, 1'b1, 1'b0);
      chk("t1_busy", 32'(busy), 32'(1));
      for (int s = 0; s < L + 3; s++) drive(1'b1, 8'(s), 1'b0, 1'b0);
      chk("t1_valid_pre", 32'(wr_valid), 32'(1));
      #2 Reset_n = 1'b0;
      #1;
      chk("t1_async_valid", 32'(wr_valid), 32'(0));
      chk("t1_async_busy", 32'(busy), 32'(0));
      chk("t1_async_ovf", 32'(overflow), 32'(0));
      chk("t1_async_addr", 32'(wr_addr), 32'(0));
      exp_q.delete();
      active = 1'b0;
      @(posedge Clk); #1;
      Reset_n = 1'b1;
      drive(1'b0, 8'd0, 1'b0, 1'b1);

      // Plain frame, always ready.
      wr_cnt = 0; d0 = done_cnt;
      drive(1'b0, 8'd0, 1'b1, 1'b1);
      for (int s = 0; s < L + W*H; s++) drive(1'b1, 8'(s), 1'b0, 1'b1);
      wait_done("t2", d0, NPIX, 1'b0);
      chk("t2_ovf", 32'(overflow), 32'(0));

`ifndef DOWNSAMPLE_EN
      // Stall the first 6 capture strobes: 4 fill the FIFO, pixels 4 and 5 are lost.
      wr_cnt = 0; d0 = done_cnt; drop_lo = 4; drop_hi = 5;
      drive(1'b0, 8'd0, 1'b1, 1'b1);
      for (int s = 0; s < L + W*H; s++)
         drive(1'b1, 8'(s), 1'b0, logic'(!(s >= L && s < L + 6)));
      wait_done("t3", d0, NPIX - 2, 1'b0);
      chk("t3_ovf", 32'(overflow), 32'(1));
      drop_lo = -1; drop_hi = -1;
`endif

      // Sparse strobes with toggling ready; overflow must clear on frame_start.
      wr_cnt = 0; d0 = done_cnt; cyc = 0;
      drive(1'b0, 8'd0, 1'b1, 1'b1);
      chk("t4_ovf_clear", 32'(overflow), 32'(0));
      for (int s = 0; s < L + W*H; s++) begin
         drive(1'b1, 8'(s), 1'b0, logic'(cyc % 2 == 0)); cyc++;
         drive(1'b0, 8'd0, 1'b0, logic'(cyc % 2 == 0)); cyc++;
         drive(1'b0, 8'd0, 1'b0, logic'(cyc % 2 == 0)); cyc++;
      end
      wait_done("t4", d0, NPIX, 1'b1);
      chk("t4_ovf", 32'(overflow), 32'(0));

      // Abort at strobe 25 with entries queued; new frame starts on that strobe.
      d0 = done_cnt;
      drive(1'b0, 8'd0, 1'b1, 1'b1);
      for (int s = 0; s < 25; s++) drive(1'b1, 8'(s), 1'b0, logic'(s < 22));
      chk("t5_valid_before", 32'(wr_valid), 32'(1));
      wr_cnt = 0;
      drive(1'b1, 8'd0, 1'b1, 1'b0);
      chk("t5_flushed", 32'(wr_valid), 32'(0));
      chk("t5_busy", 32'(busy), 32'(1));
      for (int t = 1; t < L + W*H; t++) drive(1'b1, 8'(t), 1'b0, 1'b1);
      wait_done("t5", d0, NPIX, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
